// File: rtl/uart_tx_cfg_if.sv
// Write-side handshake of the UART transmitter: a word plus send request,
// with the transmitter reporting buffer space back through ready.
interface uart_tx_cfg_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              send;
    logic              ready;

    modport master (output data, output send, input ready);
    modport slave  (input data, input send, output ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with compile-time frame format (data width,
// parity, stop bits) and a small power-of-two FIFO in front of the shifter.
module uart_tx_cfg #(
    parameter int CLK_FREQ_HZ = 5000000,
    parameter int BAUD        = 9600,
    parameter int DATA_W      = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_cfg_if.slave tx_if,
    output logic         TX,
    output logic         busy,
    output logic         tx_done
);
    localparam int DIV   = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] BAUD_LAST = DIV_W'(DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [AW:0]      FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [AW:0]       r_cnt;
    logic              r_ready;
    state_t            r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_baud, w_baud_nxt;
    logic [3:0]        r_bit, w_bit_nxt;
    logic [DATA_W-1:0] r_sh;
    logic              r_par, r_tx, r_busy, r_done;
    logic              w_push, w_pop, w_shift, w_done, w_tx, w_end;
    logic [AW:0]       w_cnt_nxt;

    assign w_push    = tx_if.send && r_ready;
    assign w_cnt_nxt = r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    assign w_end     = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_tx        = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (r_cnt != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_tx = r_sh[0];
                if (w_end) begin
                    w_baud_nxt = '0;
                    w_shift    = 1'b1;
                    if (r_bit == DATA_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                w_tx = r_par;
                if (w_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == STOP_LAST) begin
                        // Chain straight into the next start bit when work is queued.
                        w_done      = 1'b1;
                        w_bit_nxt   = '0;
                        w_pop       = (r_cnt != '0);
                        w_state_nxt = (r_cnt != '0) ? S_START : S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= tx_if.data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt != FULL);
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) begin
                r_rd  <= r_rd + 1'b1;
                r_sh  <= r_mem[r_rd];
                r_par <= (^r_mem[r_rd]) ^ 1'(PARITY == 1);
            end else if (w_shift) begin
                r_sh  <= {1'b0, r_sh[DATA_W-1:1]};
            end
            // Line outputs follow the FSM by one register stage.
            r_tx    <= w_tx;
            r_done  <= w_done;
            r_busy  <= (r_state != S_IDLE) || (r_cnt != '0);
        end
    end

    assign tx_if.ready = r_ready;
    assign TX          = r_tx;
    assign busy        = r_busy;
    assign tx_done     = r_done;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Drives several uart_tx_cfg configurations side by side and checks the
// serial line cycle by cycle against a frame model built from the format rules.
module tb_uart_tx_cfg;
    localparam int NI = 9;

    function automatic int cfg_dw(int i);
        case (i) 0: return 8; 1, 2: return 7; 3: return 8; default: return i + 1;
        endcase
    endfunction
    function automatic int cfg_par(int i);
        case (i) 0, 3: return 0; 1: return 2; default: return 1;
        endcase
    endfunction
    function automatic int cfg_stop(int i);
        case (i) 3, 6, 8: return 2; default: return 1;
        endcase
    endfunction
    function automatic int cfg_clk(int i);
        case (i) 0: return 5000000; 1, 2, 3: return 40; default: return 50;
        endcase
    endfunction
    function automatic int cfg_baud(int i);
        return (i == 0) ? 9600 : 10;
    endfunction
    function automatic int cfg_div(int i);
        case (i) 0: return 521; 1, 2, 3: return 4; default: return 5;
        endcase
    endfunction
    function automatic int frame_len(int k);
        return cfg_div(k) * (1 + cfg_dw(k) + ((cfg_par(k) != 0) ? 1 : 0) + cfg_stop(k));
    endfunction
    // Level expected on the line during bit slot b of a frame carrying w.
    function automatic logic exp_bit(int k, logic [8:0] w, int b);
        int dw, ones;
        dw = cfg_dw(k);
        ones = 0;
        if (b == 0) return 1'b0;
        if (b <= dw) return w[b-1];
        if (cfg_par(k) != 0 && b == dw + 1) begin
            for (int i = 0; i < dw; i++) ones += int'(w[i]);
            return (cfg_par(k) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
        return 1'b1;
    endfunction

    logic            clk = 1'b0;
    logic [NI-1:0]   rst_r, send_r, tx_w, rdy_w, busy_w, done_w;
    logic [8:0]      data_r [NI];
    int              done_cnt [NI];
    int              vecs = 0;
    int              errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_cfg_if #(.DATA_W(cfg_dw(g))) bus ();
        assign bus.data  = data_r[g][cfg_dw(g)-1:0];
        assign bus.send  = send_r[g];
        assign rdy_w[g]  = bus.ready;
        uart_tx_cfg #(
            .CLK_FREQ_HZ(cfg_clk(g)), .BAUD(cfg_baud(g)), .DATA_W(cfg_dw(g)),
            .PARITY(cfg_par(g)), .STOP_BITS(cfg_stop(g)), .FIFO_DEPTH(4)
        ) u_dut (
            .clk(clk), .reset(rst_r[g]), .tx_if(bus),
            .TX(tx_w[g]), .busy(busy_w[g]), .tx_done(done_w[g])
        );
    end

    always @(negedge clk)
        for (int i = 0; i < NI; i++)
            if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge where frame slot 0 should be on the line; returns one
    // sample per bit slot taken mid-bit, and leaves time at the slot after the frame.
    task automatic check_frame(int k, logic [8:0] w, string nm, output logic [15:0] mids);
        int len, div, bad, dbad;
        len = frame_len(k); div = cfg_div(k); bad = 0; dbad = 0; mids = '0;
        for (int c = 0; c < len; c++) begin
            if (tx_w[k] !== exp_bit(k, w, c / div)) bad++;
            if (done_w[k] !== (c == len - 1)) dbad++;
            if ((c % div) == div / 2) mids[c / div] = tx_w[k];
            @(negedge clk);
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL %s_line k=%0d word=%h: %0d TX cycles wrong, required 0", nm, k, w, bad);
        end
        vecs++;
        if (dbad != 0) begin
            errs++;
            $display("FAIL %s_done k=%0d: %0d tx_done cycles wrong, required single pulse on last stop cycle", nm, k, dbad);
        end
    endtask

    task automatic wait_start(int k, int bound, output bit ok);
        int n;
        n = 0;
        while (tx_w[k] !== 1'b0 && n < bound) begin @(negedge clk); n++; end
        ok = (tx_w[k] === 1'b0);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL start_bit k=%0d: TX=%b after %0d cycles, required 0", k, tx_w[k], bound);
        end
    endtask

    task automatic send_word(int k, logic [8:0] w);
        data_r[k] = w; send_r[k] = 1'b1;
        @(negedge clk);
        send_r[k] = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        repeat (3) @(negedge clk);
        vecs++; if (tx_w !== {NI{1'b1}}) begin errs++; $display("FAIL rst_tx: got %b required all 1", tx_w); end
        vecs++; if (rdy_w !== '0) begin errs++; $display("FAIL rst_ready: got %b required 0", rdy_w); end
        vecs++; if (busy_w !== '0) begin errs++; $display("FAIL rst_busy: got %b required 0", busy_w); end
        vecs++; if (done_w !== '0) begin errs++; $display("FAIL rst_done: got %b required 0", done_w); end
        rst_r = '0;
        #1;
        vecs++; if (rdy_w !== '0) begin errs++; $display("FAIL ready_pre_edge: got %b required 0", rdy_w); end
        @(negedge clk);
        vecs++; if (rdy_w !== {NI{1'b1}}) begin errs++; $display("FAIL ready_rise: got %b required all 1", rdy_w); end
        bad = 0;
        repeat (40) begin
            if (tx_w !== {NI{1'b1}} || busy_w !== '0) bad++;
            @(negedge clk);
        end
        vecs++; if (bad != 0) begin errs++; $display("FAIL no_frame_without_send: %0d bad cycles, required 0", bad); end
    endtask

    task automatic test_basic;
        logic [15:0] m;
        data_r[0] = 9'h055; send_r[0] = 1'b1;
        @(posedge clk); #1 send_r[0] = 1'b0;
        @(negedge clk);
        vecs++; if (tx_w[0] !== 1'b1) begin errs++; $display("FAIL lat_n: TX=%b required 1", tx_w[0]); end
        @(negedge clk);
        vecs++; if (tx_w[0] !== 1'b1) begin errs++; $display("FAIL lat_n1: TX=%b required 1", tx_w[0]); end
        vecs++; if (busy_w[0] !== 1'b1) begin errs++; $display("FAIL busy_queued: busy=%b required 1", busy_w[0]); end
        @(negedge clk);
        vecs++; if (tx_w[0] !== 1'b0) begin errs++; $display("FAIL lat_n2: TX=%b required 0", tx_w[0]); end
        check_frame(0, 9'h055, "f55", m);
        vecs++; if (m[9:0] !== 10'h2AA) begin errs++; $display("FAIL f55_bits: got %h required 2aa", m[9:0]); end
        vecs++;
        if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
            errs++; $display("FAIL post55: busy=%b TX=%b done=%b required 0 1 0", busy_w[0], tx_w[0], done_w[0]);
        end
    endtask

    task automatic test_parity(int k, logic pbit);
        logic [15:0] m;
        bit ok;
        send_word(k, 9'h007);
        wait_start(k, 20, ok);
        check_frame(k, 9'h007, "par", m);
        vecs++; if (m[8] !== pbit) begin errs++; $display("FAIL parity_bit k=%0d: got %b required %b", k, m[8], pbit); end
    endtask

    task automatic test_fifo_fill;
        logic [5:0] seen;
        int bad;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    data_r[3] = 9'(i + 1); send_r[3] = 1'b1; seen[i] = rdy_w[3];
                    @(negedge clk);
                end
                send_r[3] = 1'b0;
            end
            begin
                logic [15:0] m;
                bit ok;
                wait_start(3, 20, ok);
                for (int i = 1; i <= 5; i++) check_frame(3, 9'(i), "b2b", m);
            end
        join
        vecs++; if (seen !== 6'b011111) begin errs++; $display("FAIL fill_ready: got %b required 011111", seen); end
        vecs++; if (busy_w[3] !== 1'b0) begin errs++; $display("FAIL fill_busy: got %b required 0", busy_w[3]); end
        vecs++; if (rdy_w[3] !== 1'b1) begin errs++; $display("FAIL fill_ready_after: got %b required 1", rdy_w[3]); end
        bad = 0;
        repeat (3 * frame_len(3)) begin if (tx_w[3] !== 1'b1) bad++; @(negedge clk); end
        vecs++; if (bad != 0) begin errs++; $display("FAIL dropped_word_sent: %0d low cycles, required 0", bad); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] m;
        bit ok;
        int bad;
        send_word(0, 9'h0A3);
        wait_start(0, 10, ok);
        send_word(0, 9'h011);
        send_word(0, 9'h022);
        repeat (1998) @(negedge clk);
        rst_r[0] = 1'b1;
        #1;
        vecs++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            errs++; $display("FAIL mid_reset: TX=%b busy=%b ready=%b done=%b required 1 0 0 0",
                             tx_w[0], busy_w[0], rdy_w[0], done_w[0]);
        end
        repeat (3) @(negedge clk);
        rst_r[0] = 1'b0;
        bad = 0;
        repeat (6000) begin if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++; @(negedge clk); end
        vecs++; if (bad != 0) begin errs++; $display("FAIL flushed: %0d active cycles after reset, required 0", bad); end
        send_word(0, 9'h03C);
        wait_start(0, 10, ok);
        check_frame(0, 9'h03C, "f3c", m);
        bad = 0;
        repeat (30) begin if (tx_w[0] !== 1'b1) bad++; @(negedge clk); end
        vecs++; if (bad != 0) begin errs++; $display("FAIL single_frame: %0d extra low cycles, required 0", bad); end
    endtask

    task automatic test_sweep(int k);
        logic [8:0] q [$];
        int d0, dw, acc;
        dw = cfg_dw(k); d0 = done_cnt[k]; acc = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int n;
                    repeat ($urandom_range(12)) @(negedge clk);
                    n = 0;
                    while (rdy_w[k] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
                    data_r[k] = 9'($urandom) & 9'((1 << dw) - 1);
                    send_r[k] = 1'b1;
                    q.push_back(data_r[k]);
                    acc++;
                    @(negedge clk);
                    send_r[k] = 1'b0;
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [8:0]  w, rec;
                    logic [15:0] m;
                    int          ones;
                    bit          ok;
                    wait_start(k, 5000, ok);
                    if (!ok) break;
                    w = 9'h1FF;
                    if (q.size() > 0) w = q.pop_front();
                    check_frame(k, w, "sweep", m);
                    rec = '0; ones = 0;
                    for (int j = 0; j < dw; j++) begin rec[j] = m[j+1]; ones += int'(m[j+1]); end
                    vecs++; if (rec !== w) begin errs++; $display("FAIL sweep_word k=%0d: got %h required %h", k, rec, w); end
                    vecs++;
                    if (((ones + int'(m[dw+1])) % 2) != 1) begin
                        errs++; $display("FAIL sweep_parity k=%0d: parity=%b data=%h required odd total", k, m[dw+1], rec);
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        vecs++;
        if (done_cnt[k] - d0 != acc) begin
            errs++; $display("FAIL sweep_done_count k=%0d: got %0d required %0d", k, done_cnt[k] - d0, acc);
        end
    endtask

    initial begin
        rst_r  = '1;
        send_r = '0;
        for (int i = 0; i < NI; i++) data_r[i] = '0;
        test_reset();
        test_basic();
        test_parity(1, 1'b1);
        test_parity(2, 1'b0);
        test_fifo_fill();
        test_reset_mid();
        for (int k = 4; k < NI; k++) test_sweep(k);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 5000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the line rate in bits per second.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit buffer entries, a power of 2 and at least 2.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-008 The block SHALL have port reset, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-009 The block SHALL have port data, input, DATA_W bits: the word to transmit.
REQ-010 The block SHALL have port send, input, 1 bit: a write request.
REQ-011 The block SHALL have port ready, output, 1 bit: high when the FIFO can accept a word.
REQ-012 The block SHALL have port TX, output, 1 bit: the serial line, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a frame is in flight or the FIFO is non-empty.
REQ-014 The block SHALL have port tx_done, output, 1 bit: a one-cycle pulse at frame completion.

Function
REQ-015 The bit period SHALL be DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD clocks, rounded to nearest; with the defaults, DIV = 521.
REQ-016 A word SHALL be accepted on a rising edge where send = 1 and ready = 1.
REQ-017 Send while ready = 0 SHALL be ignored: no overwrite and no error flag.
REQ-018 ready SHALL equal "FIFO not full", registered, with no combinational path from send.
REQ-019 The FIFO SHALL be first-in first-out, and its pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 Simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-021 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-022 IDLE SHALL go to START when the FIFO is non-empty, popping the head word into the shift register.
REQ-023 START SHALL drive TX = 0 for DIV cycles, then go to DATA.
REQ-024 DATA SHALL send DATA_W bits LSB first, DIV cycles each.
REQ-025 After DATA, the FSM SHALL go to PARITY if PARITY != 0, else to STOP.
REQ-026 The PARITY bit SHALL make the count of ones in the data bits plus the parity bit odd (PARITY = 1) or even (PARITY = 2).
REQ-027 STOP SHALL drive TX = 1 for STOP_BITS × DIV cycles.
REQ-028 On the last STOP cycle, tx_done SHALL pulse for 1 cycle.
REQ-029 On the last STOP cycle, the FSM SHALL go to START directly if the FIFO is non-empty (no idle gap), else to IDLE.
REQ-030 Frame length SHALL be DIV × (1 + DATA_W + (PARITY != 0) + STOP_BITS) cycles exactly; with the defaults, 5210.
REQ-031 TX SHALL be a registered output.
REQ-032 When accepting into an empty FIFO in IDLE at edge N, TX SHALL go low after edge N+2 (1 cycle FIFO write, 1 cycle pop/launch).
REQ-033 Words accepted while a frame is in flight SHALL NOT alter the frame in progress.
REQ-034 busy SHALL fall in the cycle after the final tx_done when the FIFO is empty.

Reset
REQ-035 Asserting reset SHALL immediately set TX = 1, ready = 0, busy = 0, tx_done = 0, FSM = IDLE, FIFO empty, and baud/bit counters = 0.
REQ-036 While reset is high, ready SHALL be 0; ready SHALL rise on the first clock edge after reset deasserts.
REQ-037 Reset mid-frame SHALL abandon the frame and flush the FIFO, with no partial frame after release.
REQ-038 The first frame after reset SHALL begin only after a new accepted send.

Verification
REQ-039 Defaults, send data = 0x55 once -> TX = start 0, then 1,0,1,0,1,0,1,0, stop 1; each bit 521 clocks, frame 5210 clocks, one tx_done pulse.
REQ-040 PARITY = 2, DATA_W = 7, data = 0x07 -> parity bit 1; PARITY = 1, same data -> parity bit 0; frame 10 × DIV clocks.
REQ-041 FIFO_DEPTH = 4, send held high for 6 cycles with data 0x01..0x06 while idle -> exactly 5 accepted (1 popped immediately, 4 buffered); ready low after 5th; frames 0x01..0x05 back-to-back with no idle cycles between stop and start; 0x06 never sent.
REQ-042 STOP_BITS = 2 -> stop high for 2 × DIV clocks; back-to-back start follows immediately.
REQ-043 Reset asserted at clock 2000 of frame 0xA3 with 2 words queued -> TX = 1 same cycle, busy = 0, no further frames; new send 0x3C after release -> a single correct frame.
REQ-044 Parity odd, random data and config sweep DATA_W 5..9 -> a scoreboard reconstructs every word in order with correct parity; tx_done count equals accepted count.
